// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone initiator driven by a valid/ready command stream
// Optional ACK timeout: define WB_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int ADDRWIDTH      = 7,
    parameter int DATAWIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic [DATAWIDTH-1:0] cmd_dat_i,
    input  logic [3:0]           cmd_sel_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic [DATAWIDTH-1:0]   rsp_dat_q;
    logic                   cyc_q;
    logic                   we_q;
    logic [ADDRWIDTH-1:0]   adr_q;
    logic [DATAWIDTH-1:0]   dat_q;
    logic [3:0]             sel_q;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNTW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic            rsp_err_q;
    logic [CNTW-1:0] tmo_cnt_q;
    logic [CNTW-1:0] tmo_cnt_d;
    logic            tmo_hit;

    // Compare the incremented count so CYC stays high exactly TIMEOUT_CYCLES cycles.
    assign tmo_cnt_d = tmo_cnt_q + 1'b1;
    assign tmo_hit   = (tmo_cnt_d == CNTW'(TIMEOUT_CYCLES));
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            tmo_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid_i && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        cyc_q       <= 1'b1;
                        we_q        <= cmd_we_i;
                        adr_q       <= cmd_adr_i;
                        dat_q       <= cmd_dat_i;
                        sel_q       <= cmd_sel_i;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_cnt_q   <= '0;
`endif
                        state_q     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (WBm_ACK_i) begin
                        cyc_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_dat_q   <= we_q ? '0 : WBm_DAT_i;
                        rsp_valid_q <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= ST_RSP;
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        cyc_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_dat_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end else begin
                        tmo_cnt_q   <= tmo_cnt_d;
                    end
`endif
                end
                ST_RSP: begin
                    // Raise ready on exit so the next command can be taken in the first IDLE cycle.
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    cyc_q       <= 1'b0;
                    we_q        <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_dat_o      = rsp_dat_q;
    assign WBm_ADR_o      = adr_q;
    assign WBm_CYC_o      = cyc_q;
    assign WBm_STB_o      = cyc_q;
    assign WBm_WE_o       = we_q;
    assign WBm_BYTE_STB_o = sel_q;
    assign WBm_DAT_o      = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed table-driven bench for wb_cmd_master
module tb_wb_cmd_master;

    logic        WBs_CLK_i = 1'b0;
    logic        WBs_RST_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [6:0]  cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic [6:0]  WBm_ADR_o;
    logic        WBm_CYC_o;
    logic        WBm_STB_o;
    logic        WBm_WE_o;
    logic [3:0]  WBm_BYTE_STB_o;
    logic [31:0] WBm_DAT_o;
    logic [31:0] WBm_DAT_i;
    logic        WBm_ACK_i;

    always #5 WBs_CLK_i = ~WBs_CLK_i;

    wb_cmd_master dut (
        .WBs_CLK_i      (WBs_CLK_i),
        .WBs_RST_i      (WBs_RST_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_we_i       (cmd_we_i),
        .cmd_adr_i      (cmd_adr_i),
        .cmd_dat_i      (cmd_dat_i),
        .cmd_sel_i      (cmd_sel_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_dat_o      (rsp_dat_o),
        .rsp_err_o      (rsp_err_o),
        .WBm_ADR_o      (WBm_ADR_o),
        .WBm_CYC_o      (WBm_CYC_o),
        .WBm_STB_o      (WBm_STB_o),
        .WBm_WE_o       (WBm_WE_o),
        .WBm_BYTE_STB_o (WBm_BYTE_STB_o),
        .WBm_DAT_o      (WBm_DAT_o),
        .WBm_DAT_i      (WBm_DAT_i),
        .WBm_ACK_i      (WBm_ACK_i)
    );

    // Register-bank slave: ACKs one cycle after STB; word 0 holds a fixed ID value.
    logic [31:0] mem [0:127];
    logic        ack_q;
    logic        ack_off = 1'b0;

    assign WBm_ACK_i = ack_q;
    assign WBm_DAT_i = mem[WBm_ADR_o];

    always @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            ack_q <= 1'b0;
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h0000_A5BD;
        end else begin
            ack_q <= WBm_CYC_o & WBm_STB_o & ~ack_q & ~ack_off;
            if (WBm_CYC_o & WBm_STB_o & ~ack_q & ~ack_off & WBm_WE_o)
                for (int b = 0; b < 4; b++)
                    if (WBm_BYTE_STB_o[b]) mem[WBm_ADR_o][8*b +: 8] <= WBm_DAT_o[8*b +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge WBs_CLK_i);
        #1;
    endtask

    // Present a command and return one cycle after the accepting edge (cycle 1).
    task automatic issue(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output bit ok);
        int n = 0;
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 50) begin step(); n++; end
        ok = cmd_ready_o;
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat, output logic err,
                       output int lat, output int cyc_n, output bit bus_ok, output bit ok);
        bit acc;
        issue(we, adr, dat, sel, acc);
        bus_ok = (WBm_ADR_o == adr) && (WBm_WE_o == we) && (WBm_DAT_o == dat) &&
                 (WBm_BYTE_STB_o == sel);
        lat = 0; cyc_n = 0;
        while (!rsp_valid_o && lat < 1000) begin
            if (WBm_CYC_o && WBm_STB_o) cyc_n++;
            step();
            lat++;
        end
        ok = acc && rsp_valid_o;
        rdat = rsp_dat_o;
        err = rsp_err_o;
        step();
    endtask

    typedef struct {
        logic        we;
        logic [6:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdat;
        logic        err;
        int          lat, cyc_n, n;
        bit          bus_ok, ok, bad;
        logic [31:0] held;

        vecs[0] = '{1'b1, 7'h02, 32'h0000_1234, 4'hF, 32'h0000_0000};
        vecs[1] = '{1'b0, 7'h02, 32'h0000_0000, 4'hF, 32'h0000_1234};
        vecs[2] = '{1'b0, 7'h00, 32'h0000_0000, 4'hF, 32'h0000_A5BD};
        vecs[3] = '{1'b1, 7'h04, 32'h0705_0301, 4'b0101, 32'h0000_0000};
        vecs[4] = '{1'b0, 7'h04, 32'h0000_0000, 4'hF, 32'h0005_0001};
        vecs[5] = '{1'b1, 7'h10, 32'hDEAD_BEEF, 4'b1000, 32'h0000_0000};
        vecs[6] = '{1'b0, 7'h10, 32'h0000_0000, 4'hF, 32'hDE00_0000};
        vecs[7] = '{1'b1, 7'h7F, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        vecs[8] = '{1'b0, 7'h7F, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF};

        // Reset state
        repeat (2) @(posedge WBs_CLK_i);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_rsp_dat", rsp_dat_o, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'h0);
        chk("rst_cyc_stb_we", {29'h0, WBm_CYC_o, WBm_STB_o, WBm_WE_o}, 32'h0);
        chk("rst_adr_sel", {21'h0, WBm_ADR_o, WBm_BYTE_STB_o}, 32'h0);
        chk("rst_dat", WBm_DAT_o, 32'h0);
        WBs_RST_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rdat, err, lat, cyc_n, bus_ok, ok);
            chk($sformatf("v%0d_done", i), 32'(ok), 32'h1);
            chk($sformatf("v%0d_bus", i), 32'(bus_ok), 32'h1);
            chk($sformatf("v%0d_rdat", i), rdat, vecs[i].exp);
            chk($sformatf("v%0d_err", i), 32'(err), 32'h0);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_cyc_cycles", i), 32'(cyc_n), 32'd2);
            chk($sformatf("v%0d_next_ready", i), 32'(cmd_ready_o), 32'h1);
            chk($sformatf("v%0d_idle_bus", i), {29'h0, WBm_CYC_o, WBm_STB_o, WBm_WE_o}, 32'h0);
            chk($sformatf("v%0d_adr_hold", i), 32'(WBm_ADR_o), 32'(vecs[i].adr));
        end

        // Response back-pressure: held response, no new bus cycle while a command waits
        rsp_ready_i = 1'b0;
        txn(1'b0, 7'h00, 32'h0, 4'hF, rdat, err, lat, cyc_n, bus_ok, ok);
        chk("stall_done", 32'(ok), 32'h1);
        chk("stall_rdat", rdat, 32'h0000_A5BD);
        held = rsp_dat_o;
        cmd_we_i = 1'b0; cmd_adr_i = 7'h02; cmd_valid_i = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!rsp_valid_o || rsp_dat_o !== held || cmd_ready_o || WBm_CYC_o || WBm_STB_o)
                bad = 1'b1;
            step();
        end
        chk("stall_stable", 32'(bad), 32'h0);
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        step();
        chk("stall_release_valid", 32'(rsp_valid_o), 32'h0);
        chk("stall_release_ready", 32'(cmd_ready_o), 32'h1);

        // Slave never ACKs
        ack_off = 1'b1;
        issue(1'b0, 7'h00, 32'h0, 4'hF, ok);
        chk("noack_accept", 32'(ok), 32'h1);
`ifdef WB_MASTER_TIMEOUT_EN
        n = 0; cyc_n = 0;
        while (!rsp_valid_o && n < 1000) begin
            if (WBm_CYC_o) cyc_n++;
            step();
            n++;
        end
        chk("tmo_cyc_cycles", 32'(cyc_n), 32'd255);
        chk("tmo_valid", 32'(rsp_valid_o), 32'h1);
        chk("tmo_err", 32'(rsp_err_o), 32'h1);
        chk("tmo_dat", rsp_dat_o, 32'h0);
        chk("tmo_cyc_low", 32'(WBm_CYC_o), 32'h0);
        step();
        issue(1'b0, 7'h00, 32'h0, 4'hF, ok);
        repeat (5) step();
`else
        bad = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!WBm_CYC_o || !WBm_STB_o || rsp_valid_o || rsp_err_o) bad = 1'b1;
            step();
        end
        chk("noack_wait_forever", 32'(bad), 32'h0);
`endif

        // Asynchronous reset mid-transaction
        chk("pre_reset_cyc", 32'(WBm_CYC_o), 32'h1);
        #2;
        WBs_RST_i = 1'b1;
        #1;
        chk("async_rst_bus", {30'h0, WBm_CYC_o, WBm_STB_o}, 32'h0);
        chk("async_rst_rsp", 32'(rsp_valid_o), 32'h0);
        ack_off = 1'b0;
        repeat (2) step();
        WBs_RST_i = 1'b0;
        txn(1'b0, 7'h00, 32'h0, 4'hF, rdat, err, lat, cyc_n, bus_ok, ok);
        chk("post_rst_done", 32'(ok), 32'h1);
        chk("post_rst_rdat", rdat, 32'h0000_A5BD);
        chk("post_rst_err", 32'(err), 32'h0);
        chk("post_rst_lat", 32'(lat), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
